// File: rtl/gray_counter_param.sv
// WIDTH-bit up/down Gray-code counter with parallel load, wrap pulse and a
// sticky-or-pulsed overflow flag. All outputs are registered from one binary count.
module gray_counter_param #(
   parameter int unsigned WIDTH      = 3,
   parameter bit          OVF_STICKY = 1'b1
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic             Dir,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadVal,
   input  logic             ClrOvf,
   output logic [WIDTH-1:0] Output,
   output logic [WIDTH-1:0] BinOut,
   output logic             Overflow,
   output logic             Wrap
);

   localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_wrap;
   logic             r_ovf;

   logic [WIDTH-1:0] w_bin_next;
   logic [WIDTH-1:0] w_gray_next;
   logic             w_up_wrap;
   logic             w_dn_wrap;
   logic             w_wrap_next;
   logic             w_ovf_next;

   always_comb begin
      w_up_wrap   = En & ~Load & Dir & (r_bin == MAX_VAL);
      w_dn_wrap   = En & ~Load & ~Dir & (r_bin == '0);
      w_wrap_next = w_up_wrap | w_dn_wrap;

      w_bin_next = r_bin;
      if (Load) begin
         w_bin_next = LoadVal;
      end else if (En) begin
         w_bin_next = Dir ? (r_bin + ONE) : (r_bin - ONE);
      end

      // Gray is encoded from the next count so it lands in the same edge as BinOut
      w_gray_next = w_bin_next ^ (w_bin_next >> 1);

      if (OVF_STICKY) begin
         // A wrap at the same edge as ClrOvf keeps the flag set
         w_ovf_next = w_wrap_next | (r_ovf & ~ClrOvf);
      end else begin
         w_ovf_next = w_wrap_next;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_bin  <= '0;
         r_gray <= '0;
         r_wrap <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_bin  <= w_bin_next;
         r_gray <= w_gray_next;
         r_wrap <= w_wrap_next;
         r_ovf  <= w_ovf_next;
      end
   end

   assign Output   = r_gray;
   assign BinOut   = r_bin;
   assign Wrap     = r_wrap;
   assign Overflow = r_ovf;

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboard bench for gray_counter_param: a 3-bit sticky build and a 4-bit
// pulsed build, each tracked by a reference model.
module tb_gray_counter_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       a_en, a_dir, a_load, a_clr;
   logic [2:0] a_lv, a_gray, a_bin;
   logic       a_ovf, a_wrap;
   logic       b_en, b_dir, b_load, b_clr;
   logic [3:0] b_lv, b_gray, b_bin;
   logic       b_ovf, b_wrap;

   gray_counter_param #(.WIDTH(3), .OVF_STICKY(1'b1)) u_dut_a (
      .Clk(clk), .Reset(rst_n), .En(a_en), .Dir(a_dir), .Load(a_load), .LoadVal(a_lv),
      .ClrOvf(a_clr), .Output(a_gray), .BinOut(a_bin), .Overflow(a_ovf), .Wrap(a_wrap)
   );

   gray_counter_param #(.WIDTH(4), .OVF_STICKY(1'b0)) u_dut_b (
      .Clk(clk), .Reset(rst_n), .En(b_en), .Dir(b_dir), .Load(b_load), .LoadVal(b_lv),
      .ClrOvf(b_clr), .Output(b_gray), .BinOut(b_bin), .Overflow(b_ovf), .Wrap(b_wrap)
   );

   typedef struct {
      bit         sel;
      string      tag;
      logic [3:0] gray;
      logic [3:0] bin;
      logic       wrap;
      logic       ovf;
   } exp_t;

   exp_t sb_q[$];
   int   n_pass  = 0;
   int   n_total = 0;

   logic [3:0] ma_bin, mb_bin;
   logic       ma_wrap, ma_ovf, mb_wrap, mb_ovf;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   function automatic logic [3:0] to_gray(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic model_step(input int w, input bit sticky, input logic en, input logic dir,
                             input logic load, input logic clr, input logic [3:0] lv,
                             inout logic [3:0] bin, inout logic wr, inout logic ov);
      logic [4:0] full;
      logic [3:0] maxv;
      logic       hit;
      full = (5'd1 << w) - 5'd1;
      maxv = full[3:0];
      hit  = en & ~load & ((dir & (bin == maxv)) | (~dir & (bin == 4'd0)));
      ov   = sticky ? (hit | (ov & ~clr)) : hit;
      wr   = hit;
      if (load) bin = lv & maxv;
      else if (en) bin = (dir ? bin + 4'd1 : bin - 4'd1) & maxv;
   endtask

   task automatic model_reset();
      ma_bin = '0; ma_wrap = 1'b0; ma_ovf = 1'b0;
      mb_bin = '0; mb_wrap = 1'b0; mb_ovf = 1'b0;
   endtask

   task automatic compare_pop();
      exp_t e;
      if (sb_q.size() == 0) begin
         check_eq("sb_underflow", 32'd0, 32'd1);
         return;
      end
      e = sb_q.pop_front();
      if (e.sel == 1'b0) begin
         check_eq({e.tag, ".gray"}, {29'd0, a_gray}, {28'd0, e.gray});
         check_eq({e.tag, ".bin"},  {29'd0, a_bin},  {28'd0, e.bin});
         check_eq({e.tag, ".wrap"}, {31'd0, a_wrap}, {31'd0, e.wrap});
         check_eq({e.tag, ".ovf"},  {31'd0, a_ovf},  {31'd0, e.ovf});
      end else begin
         check_eq({e.tag, ".gray"}, {28'd0, b_gray}, {28'd0, e.gray});
         check_eq({e.tag, ".bin"},  {28'd0, b_bin},  {28'd0, e.bin});
         check_eq({e.tag, ".wrap"}, {31'd0, b_wrap}, {31'd0, e.wrap});
         check_eq({e.tag, ".ovf"},  {31'd0, b_ovf},  {31'd0, e.ovf});
      end
   endtask

   task automatic step_a(input string tag, input logic en, input logic dir, input logic load,
                         input logic clr, input logic [2:0] lv);
      exp_t e;
      a_en = en; a_dir = dir; a_load = load; a_clr = clr; a_lv = lv;
      b_en = 1'b0; b_load = 1'b0; b_clr = 1'b0;
      model_step(3, 1'b1, en, dir, load, clr, {1'b0, lv}, ma_bin, ma_wrap, ma_ovf);
      model_step(4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, mb_bin, mb_wrap, mb_ovf);
      e = '{sel: 1'b0, tag: tag, gray: to_gray(ma_bin), bin: ma_bin, wrap: ma_wrap, ovf: ma_ovf};
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      compare_pop();
   endtask

   task automatic step_b(input string tag, input logic en, input logic dir, input logic clr);
      exp_t e;
      b_en = en; b_dir = dir; b_load = 1'b0; b_clr = clr; b_lv = 4'd0;
      a_en = 1'b0; a_load = 1'b0; a_clr = 1'b0;
      model_step(4, 1'b0, en, dir, 1'b0, clr, 4'd0, mb_bin, mb_wrap, mb_ovf);
      model_step(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, ma_bin, ma_wrap, ma_ovf);
      e = '{sel: 1'b1, tag: tag, gray: to_gray(mb_bin), bin: mb_bin, wrap: mb_wrap, ovf: mb_ovf};
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      compare_pop();
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      model_reset();
      rst_n = 1'b1;
   endtask

   logic [2:0] up_tab[8];
   logic [3:0] prev_gray;

   initial begin
      up_tab = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
      rst_n = 1'b0;
      a_en = 0; a_dir = 0; a_load = 0; a_clr = 0; a_lv = '0;
      b_en = 0; b_dir = 0; b_load = 0; b_clr = 0; b_lv = '0;
      model_reset();

      // Outputs held at zero across a clock edge while in reset
      #12;
      check_eq("rst.a_gray", {29'd0, a_gray}, 32'd0);
      check_eq("rst.a_bin",  {29'd0, a_bin},  32'd0);
      check_eq("rst.a_flags", {30'd0, a_wrap, a_ovf}, 32'd0);
      check_eq("rst.b_all", {22'd0, b_gray, b_bin, b_wrap, b_ovf}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         step_a($sformatf("up%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
         check_eq($sformatf("up_tab%0d", i), {29'd0, a_gray}, {29'd0, up_tab[i]});
      end
      step_a("up_after_wrap0", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      step_a("up_after_wrap1", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);

      pulse_reset();
      step_a("dn_wrap", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      check_eq("dn_wrap.const", {26'd0, a_bin, a_gray}, {26'd0, 3'd7, 3'b100});
      step_a("dn6", 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      check_eq("dn6.const", {26'd0, a_bin, a_gray}, {26'd0, 3'd6, 3'b101});

      step_a("load5", 1'b1, 1'b1, 1'b1, 1'b0, 3'd5);
      check_eq("load5.gray_const", {29'd0, a_gray}, {29'd0, 3'b111});
      step_a("hold5", 1'b0, 1'b1, 1'b0, 1'b0, 3'd2);

      step_a("load7", 1'b0, 1'b1, 1'b1, 1'b0, 3'd7);
      step_a("clr_vs_wrap", 1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
      check_eq("clr_vs_wrap.ovf_const", {31'd0, a_ovf}, 32'd1);
      step_a("clr_ok", 1'b1, 1'b1, 1'b0, 1'b1, 3'd0);
      check_eq("clr_ok.ovf_const", {31'd0, a_ovf}, 32'd0);

      step_a("to3", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      step_a("at3", 1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
      check_eq("at3.bin_const", {29'd0, a_bin}, 32'd3);

      // Asynchronous reset between edges
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst.a", {24'd0, a_gray, a_bin, a_wrap, a_ovf}, 32'd0);
      model_reset();
      #2;
      rst_n = 1'b1;
      step_a("hold0a", 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
      step_a("hold0b", 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

      pulse_reset();
      prev_gray = b_gray;
      for (int i = 0; i < 16; i++) begin
         step_b($sformatf("b_up%0d", i), 1'b1, 1'b1, (i % 3) == 0);
         check_eq($sformatf("b_ham%0d", i), $countones(prev_gray ^ b_gray), 32'd1);
         prev_gray = b_gray;
      end
      step_b("b_after_wrap", 1'b1, 1'b1, 1'b0);

      check_eq("sb_empty", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/gray_counter_param.md
Name: gray_counter_param

Overview:
- Parametrised successor to the team's fixed 3-bit Gray counter.
- WIDTH-bit up/down Gray-code counter with enable, synchronous parallel load, and a wrap-detect pulse.
- Overflow flag is configurable as sticky or pulsed, with an explicit clear.
- Used wherever multi-bit state must change one bit per step: pointer sync, position encoders, sequencing in datapath labs.

Parameters:
- WIDTH, 3, counter width in bits; legal range 2..16.
- OVF_STICKY, 1; 1 = Overflow holds until ClrOvf or reset; 0 = Overflow mirrors Wrap.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous reset, active-low (0 = reset).
- En  input  1  count enable; one step per Clk edge while high.
- Dir  input  1  direction: 1 = up, 0 = down.
- Load  input  1  synchronous parallel load strobe.
- LoadVal  input  WIDTH  binary value to load.
- ClrOvf  input  1  synchronous clear of the sticky Overflow.
- Output  output  WIDTH  registered Gray code of the count.
- BinOut  output  WIDTH  registered binary count.
- Overflow  output  1  wrap indication, behaviour per OVF_STICKY.
- Wrap  output  1  one-cycle pulse marking a wrap transition.

Behaviour:
- Reset low (async, any time, including mid-count):
  - Reset value of every output is 0: BinOut=0, Output=0, Overflow=0, Wrap=0.
  - Outputs stay 0 until the first Clk edge after Reset returns high.
- Internal state is the binary count B; all outputs are registered.
- Output = next_B ^ (next_B >> 1), registered in the same edge as B.
  - Output and BinOut are therefore always consistent; Output is never derived combinationally from a register.
- Per-edge priority: Load > En > hold.
  - Load=1: B <= LoadVal regardless of En/Dir; Wrap <= 0; Overflow is unaffected by the load itself.
  - Load=0, En=1, Dir=1: B <= B+1 modulo 2^WIDTH.
  - Load=0, En=1, Dir=0: B <= B-1 modulo 2^WIDTH.
  - Load=0, En=0: B holds; Wrap <= 0.
- Wrap detection (combinational on current state):
  - up wrap = En & ~Load & Dir & (B == 2^WIDTH-1).
  - down wrap = En & ~Load & ~Dir & (B == 0).
  - Wrap register <= up wrap | down wrap.
  - Wrap is high exactly in the cycle the wrapped value (0 or max) is first visible on the outputs.
- Overflow, OVF_STICKY=1:
  - Set when a wrap occurs; held through further counting, loads and direction changes.
  - Cleared only by ClrOvf=1 at an edge or by reset.
  - ClrOvf and a wrap at the same edge: set wins, Overflow stays 1.
- Overflow, OVF_STICKY=0: Overflow register equals the Wrap register; ClrOvf is ignored.
- Direction change takes effect on the very next enabled edge; there is no dead cycle.
- Latency: any input change is visible on outputs after 1 Clk edge.
- Gray property: successive enabled, non-load outputs differ in exactly one bit, including across wrap in both directions.

Test Plan:
- WIDTH=3, reset release, En=1, Dir=1 for 8 edges:
  - Output sequence 001,011,010,110,111,101,100,000.
  - On the 8th edge Output=000, BinOut=0, Wrap=1 for one cycle, Overflow=1 and stays 1 while counting on.
- WIDTH=3 from reset, Dir=0, En=1, one edge -> BinOut=7, Output=100, Wrap=1, Overflow=1; next edge BinOut=6, Output=101, Wrap=0.
- Load=1, LoadVal=5, En=1 simultaneously -> BinOut=5, Output=111, Wrap=0, Overflow unchanged.
- Overflow=1, counter at 7, Dir=1, En=1, ClrOvf=1 at the same edge -> Overflow stays 1; next edge with ClrOvf=1 and no wrap -> Overflow=0.
- Mid-count at BinOut=3, drive Reset=0 between edges -> all outputs 0 immediately, without waiting for Clk; En=0 afterwards -> outputs hold 0.
- Second build with WIDTH=4, OVF_STICKY=0, 16 up steps:
  - Every transition has Hamming distance 1.
  - Wrap and Overflow are both high only on the 15->0 edge, low on all others.
